// File: rtl/bsg_vc_output_scheduler.sv
// Round-robin flit scheduler for several virtual channels sharing one output link.
// It has per-VC credit counters and tracks header/body packet state for each VC.
module bsg_vc_output_scheduler #(
  parameter int vc_num_p    = 2,
  parameter int len_width_p = 4,
  parameter int credits_p   = 4,
  localparam int tag_width_lp  = (vc_num_p > 1) ? $clog2(vc_num_p) : 1,
  localparam int cred_width_lp = $clog2(credits_p + 1)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic [vc_num_p-1:0]                         v_i,
  input  logic [vc_num_p-1:0][len_width_p-1:0]        hdr_len_i,
  input  logic [vc_num_p-1:0]                         credit_return_i,
  output logic [vc_num_p-1:0]                         yumi_o,
  output logic                                        v_o,
  output logic [tag_width_lp-1:0]                     tag_o,
  output logic [vc_num_p-1:0][cred_width_lp-1:0]      credits_o,
  output logic [vc_num_p-1:0]                         in_pkt_o
);

  localparam logic [cred_width_lp-1:0] cred_max_lp  = cred_width_lp'(credits_p);
  localparam logic [cred_width_lp-1:0] cred_one_lp  = cred_width_lp'(1);
  localparam logic [len_width_p-1:0]   rem_one_lp   = len_width_p'(1);
  localparam logic [tag_width_lp-1:0]  last_init_lp = tag_width_lp'(vc_num_p - 1);

  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} vc_state_e;

  vc_state_e                               state   [vc_num_p];
  vc_state_e                               state_n [vc_num_p];
  logic [len_width_p-1:0]                  rem     [vc_num_p];
  logic [len_width_p-1:0]                  rem_n   [vc_num_p];
  logic [vc_num_p-1:0][cred_width_lp-1:0]  credits;
  logic [vc_num_p-1:0][cred_width_lp-1:0]  credits_n;
  logic [tag_width_lp-1:0]                 last_grant;
  logic [vc_num_p-1:0]                     elig;
  logic [tag_width_lp:0]                   pick;
  logic                                    grant_v;
  logic [tag_width_lp-1:0]                 winner;
  logic [vc_num_p-1:0]                     yumi;

  // Scans from last+vc_num_p down to last+1 so the nearest eligible VC after last wins.
  function automatic logic [tag_width_lp:0] rr_pick(input logic [vc_num_p-1:0] el,
                                                    input logic [tag_width_lp-1:0] last);
    logic [tag_width_lp:0] res;
    int idx;
    res = '0;
    for (int k = vc_num_p; k >= 1; k--) begin
      idx = (int'(last) + k) % vc_num_p;
      if (el[idx]) res = {1'b1, idx[tag_width_lp-1:0]};
    end
    return res;
  endfunction

  function automatic logic [cred_width_lp-1:0] cred_next(input logic [cred_width_lp-1:0] cur,
                                                        input logic take,
                                                        input logic give);
    logic [cred_width_lp-1:0] nxt;
    nxt = cur;
    if (take && !give)
      nxt = cur - cred_one_lp;
    else if (give && !take && cur != cred_max_lp)
      nxt = cur + cred_one_lp;
    return nxt;
  endfunction

  always_comb begin
    for (int i = 0; i < vc_num_p; i++)
      elig[i] = v_i[i] && (credits[i] != '0);
  end

  assign pick = rr_pick(elig, last_grant);

  always_comb begin
    grant_v = 1'b0;
    winner  = '0;
    yumi    = '0;
    if (reset_n_i && pick[tag_width_lp]) begin
      grant_v = 1'b1;
      winner  = pick[tag_width_lp-1:0];
      yumi    = vc_num_p'(1) << winner;
    end
  end

  // A return arriving with a grant only cancels the decrement; it never enables the grant.
  always_comb begin
    for (int i = 0; i < vc_num_p; i++) begin
      state_n[i]   = state[i];
      rem_n[i]     = rem[i];
      credits_n[i] = cred_next(credits[i], yumi[i], credit_return_i[i]);
      if (yumi[i]) begin
        if (state[i] == BODY) begin
          rem_n[i] = rem[i] - rem_one_lp;
          if (rem[i] == rem_one_lp) state_n[i] = HEAD;
        end else if (hdr_len_i[i] != '0) begin
          state_n[i] = BODY;
          rem_n[i]   = hdr_len_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_grant <= last_init_lp;
      for (int i = 0; i < vc_num_p; i++) begin
        state[i]   <= HEAD;
        rem[i]     <= '0;
        credits[i] <= cred_max_lp;
      end
    end else begin
      if (grant_v) last_grant <= winner;
      for (int i = 0; i < vc_num_p; i++) begin
        state[i]   <= state_n[i];
        rem[i]     <= rem_n[i];
        credits[i] <= credits_n[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < vc_num_p; i++)
      in_pkt_o[i] = (state[i] == BODY);
  end

  assign yumi_o    = yumi;
  assign v_o       = grant_v;
  assign tag_o     = winner;
  assign credits_o = credits;

`ifndef SYNTHESIS
  for (genvar g = 0; g < vc_num_p; g++) begin : g_cred_chk
    a_cred_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(credit_return_i[g] && !yumi[g] && credits[g] == cred_max_lp));
  end
`endif

endmodule

// File: doc/bsg_vc_output_scheduler.md
BSG_VC_OUTPUT_SCHEDULER -- requirements
Module: bsg_vc_output_scheduler

Interface
REQ-001 SHALL have parameter vc_num_p, default 2, number of virtual channels sharing one output link.
REQ-002 SHALL have parameter len_width_p, default 4, width of the packet-length field carried in a header flit.
REQ-003 SHALL have parameter credits_p, default 4, downstream input-buffer depth per VC (credit pool size).
REQ-004 SHALL define tag_width_lp = BSG_SAFE_CLOG2(vc_num_p) and cred_width_lp = clog2(credits_p+1).
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n_i  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port v_i  input  [vc_num_p]  per-VC flit valid from that VC's router output.
REQ-008 SHALL have port hdr_len_i  input  [vc_num_p][len_width_p]  per-VC body-flit count, meaningful only when that VC's pending flit is a header.
REQ-009 SHALL have port credit_return_i  input  [vc_num_p]  downstream freed one slot of that VC, one credit per bit per cycle.
REQ-010 SHALL have port yumi_o  output  [vc_num_p]  one-hot-or-zero: the flit of that VC is consumed this cycle.
REQ-011 SHALL have port v_o  output  1  a flit is sent on the output link this cycle.
REQ-012 SHALL have port tag_o  output  [tag_width_lp]  index of the VC sent; 0 when v_o=0.
REQ-013 SHALL have port credits_o  output  [vc_num_p][cred_width_lp]  current credit count per VC.
REQ-014 SHALL have port in_pkt_o  output  [vc_num_p]  VC is in BODY state (header sent, tail not yet sent).

Function
REQ-015 SHALL treat VC i as eligible when v_i[i]=1 and credits_o[i]>0.
REQ-016 SHALL grant combinationally in the same cycle (zero latency): v_o = OR of eligibility, yumi_o = one-hot of the winner, tag_o = winner index.
REQ-017 SHALL arbitrate round-robin at flit granularity: search starts at last_grant+1 modulo vc_num_p; flits of different VCs may interleave.
REQ-018 SHALL update last_grant only on a cycle with v_o=1; otherwise hold it.
REQ-019 SHALL keep per-VC state HEAD or BODY plus a len_width_p-bit remaining counter rem[i].
REQ-020 SHALL, on grant of VC i in HEAD: if hdr_len_i[i]=0, stay HEAD (single-flit packet); else go BODY with rem[i]=hdr_len_i[i].
REQ-021 SHALL, on grant of VC i in BODY: decrement rem[i]; when rem[i]=1 before the grant, return to HEAD (tail flit).
REQ-022 SHALL hold state and rem of any VC not granted, regardless of v_i.
REQ-023 SHALL decrement credits[i] on yumi_o[i] and increment on credit_return_i[i]; both in the same cycle leave it unchanged.
REQ-024 SHALL never grant VC i with credits[i]=0, even if a return for i arrives that cycle (the return is visible next cycle).
REQ-025 SHALL saturate credits[i] at credits_p; a return when full with no grant is an error, flagged by a simulation-only assertion, and the count stays credits_p.
REQ-026 SHALL ignore hdr_len_i of a VC in BODY state.

Reset
REQ-027 SHALL, when reset_n_i=0 at a clock edge, set all VCs to HEAD, rem=0, credits=credits_p, last_grant=vc_num_p-1 (VC0 has first priority).
REQ-028 SHALL force yumi_o=0, v_o=0, tag_o=0 while reset_n_i=0, and ignore credit_return_i during reset.
REQ-029 SHALL abandon any packet in flight on reset; no partial-packet state survives.

Verification
REQ-030 SHALL cover: after reset, v_i=2'b11, hdr_len=0 both -> grants alternate VC0,VC1,VC0,... and tag_o 0,1,0.
REQ-031 SHALL cover: VC0 only, header hdr_len=3 then 3 bodies -> in_pkt_o[0]=1 for cycles 2-4, back to HEAD after 4th flit; credits_o[0] 4,3,2,1,0.
REQ-032 SHALL cover: credits_p=4, VC1 sends 4 flits, no returns -> 5th cycle yumi_o[1]=0, v_o=0; credit_return_i[1] pulse -> grant next cycle.
REQ-033 SHALL cover: grant and credit_return_i on same VC same cycle -> credits_o unchanged (e.g. stays 2).
REQ-034 SHALL cover: reset_n_i low mid-packet (rem=2) -> next cycle in_pkt_o=0, credits=credits_p, VC0 wins first tie.
REQ-035 SHALL cover: VC0 credits=0, VC1 eligible -> VC1 granted every cycle, no stall from VC0's blocked packet.
